alu_muldiv_iter: RTL
====================

Name: alu_muldiv_iter

Overview:
- Parametrised multi-cycle multiply/divide unit: the successor to the 2-bit-control combinational ALU.
- Executes the RV32M operation set (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) iteratively, one bit per cycle.
- Uses a start/ready/valid handshake so the core can stall while it runs.
- Sits beside the existing ALU in the execute stage and shares its operand and result buses.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 4 and even.
- CNT_W, $clog2(WIDTH), iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when ready=1
- alu_control  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- input_1  in  WIDTH  rs1 operand (multiplicand/dividend)
- input_2  in  WIDTH  rs2 operand (multiplier/divisor)
- ready  out  1  idle; may accept start
- result_valid  out  1  one-cycle pulse: alu_result is new
- alu_result  out  WIDTH  result; held until the next completion

Behaviour:
- Reset, asynchronous while rst_n=0:
  - state=IDLE, ready=1, result_valid=0, alu_result=0, counter=0, internal registers=0.
  - Reset asserted mid-operation aborts it; no result_valid is produced.
- States: IDLE, CALC, DONE.
  - IDLE: ready=1. On start=1, latch op and operands, then go to CALC (or directly to DONE for a special case).
  - CALC: ready=0. One iteration per cycle; counter loads WIDTH-1 and decrements; at the edge where counter==0, apply sign fix, register alu_result, go to DONE.
  - DONE: ready=0, result_valid=1 for exactly one cycle; then IDLE.
- Latency:
  - Normal ops: start accepted at edge N, result_valid high in the cycle after edge N+WIDTH. That is WIDTH+1 cycles, 33 for WIDTH=32.
  - Back-to-back throughput is one op per WIDTH+2 cycles.
- Operand capture: operands are latched at acceptance; later changes on input_1/input_2/alu_control have no effect.
- start while ready=0 is ignored (not queued).
- Multiply:
  - Shift-add on operand magnitudes into a 2*WIDTH accumulator.
  - MUL returns the low WIDTH bits; MULH/MULHSU/MULHU return the high WIDTH bits.
  - Signedness: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - Product sign is negated at completion if the operand signs differ (signed operands only).
- Divide: restoring division on magnitudes, one quotient bit per cycle.
  - Quotient is truncated toward zero.
  - Remainder takes the sign of the dividend.
- Special cases, result available in 1 cycle (accept → DONE directly, result_valid in the cycle after the accept edge):
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return input_1.
  - Signed overflow (DIV/REM with input_1 = 1 followed by zeros and input_2 = all-ones): DIV returns input_1; REM returns 0.
- Width rules: the most negative value is handled via a WIDTH+1-bit magnitude or an unsigned WIDTH-bit magnitude; no overflow is flagged.
- alu_result changes only on the edge entering DONE.

Decomposition:
- Shared package alu_muldiv_pkg:
  - 3-bit op encoding constants (OP_MUL … OP_REMU).
  - State encoding localparams.
  - Helper function is_signed_op.
- One natural sub-module: alu_muldiv_divstep, the combinational restoring-divide step (partial remainder shift/subtract/select, WIDTH-parametrised).
- Multiply step is simple enough to stay inline.

Test Plan (WIDTH=32):
- MUL 23×42, start pulse at edge 0 → ready low for 33 cycles; result_valid pulses once with alu_result=966; ready high next cycle.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7%2 → 0xFFFFFFFF; DIVU 42/23 → 1; REMU 42%23 → 19.
- DIVU 5/0 → 0xFFFFFFFF, REM 5%0 → 5, DIV 0x80000000/-1 → 0x80000000, REM same → 0; each with result_valid exactly one cycle after the accept edge.
- start held high and operands changed during CALC → no second acceptance; result uses the latched operands; the next op is accepted only when ready=1.
- rst_n pulsed low mid-CALC (cycle 10, asynchronous, off-edge) → ready=1, result_valid=0, alu_result=0 immediately; no result_valid follows; a new MUL 3×4 then completes with 12.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Holds the op encodings, FSM state encoding and operand signedness helpers.
// No logic of its own; imported by alu_muldiv_iter and alu_muldiv_divstep.
package alu_muldiv_pkg;

  // alu_control encodings (RV32M funct3 order)
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_CALC_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_CALC = ST_CALC_ENC,
    ST_DONE = ST_DONE_ENC
  } state_t;

  // rs1 is interpreted as two's complement for this op
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is interpreted as two's complement for this op
  function automatic logic is_signed_rs2(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_muldiv_divstep.sv
// One restoring-division step: shift next dividend bit into the partial remainder, subtract if it fits.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
// Ports: rem_in/rem_out partial remainder (always < divisor), dividend_bit next dividend bit (MSB first),
//        divisor divisor magnitude, quo_bit quotient bit produced by this step.
module alu_muldiv_divstep
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             quo_bit
);

  logic [WIDTH-1:0] shifted;

  // The shifted remainder is really WIDTH+1 bits; if the bit that falls off the top is set,
  // the value is >= 2^WIDTH and therefore certainly >= divisor. The low WIDTH bits of the
  // difference are exact because the true remainder after subtraction is < divisor.
  always_comb begin
    shifted = {rem_in[WIDTH-2:0], dividend_bit};
    quo_bit = rem_in[WIDTH-1] | (shifted >= divisor);
    rem_out = quo_bit ? (shifted - divisor) : shifted;
  end

endmodule

// File: rtl/alu_muldiv_iter.sv
// Iterative RV32M multiply/divide unit, one bit per cycle over operand magnitudes with a final sign fix.
// Latency: WIDTH+1 cycles from accept to result_valid; divide-by-zero and signed overflow take 1 cycle.
// Backpressure: start is taken only while ready=1; start during an operation is dropped, not queued.
// Ports: clk, rst_n (async active-low); start/alu_control/input_1/input_2 request;
//        ready idle flag; result_valid one-cycle completion pulse; alu_result held until next completion.
module alu_muldiv_iter
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] input_1,
  input  logic [WIDTH-1:0] input_2,
  output logic             ready,
  output logic             result_valid,
  output logic [WIDTH-1:0] alu_result
);

  localparam int CNT_W = $clog2(WIDTH);

  if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("alu_muldiv_iter: WIDTH must be even and >= 4");
  end

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               neg_res;    // product / quotient sign
  logic               neg_rem;    // remainder follows dividend sign
  logic [2*WIDTH-1:0] acc;        // product accumulator
  logic [WIDTH-1:0]   quo, rem;

  // ---------------- acceptance-side decode ----------------
  logic             a_neg, b_neg;
  logic             div_zero, div_ovf, special_case;
  logic [WIDTH-1:0] special_res;

  always_comb begin
    a_neg        = is_signed_op(alu_control) & input_1[WIDTH-1];
    b_neg        = is_signed_rs2(alu_control) & input_2[WIDTH-1];
    div_zero     = alu_control[2] & (input_2 == '0);
    // most-negative / -1 only overflows for the signed DIV/REM ops (bit0 clear)
    div_ovf      = alu_control[2] & ~alu_control[0] &
                   (input_1 == {1'b1, {(WIDTH-1){1'b0}}}) & (input_2 == '1);
    special_case = div_zero | div_ovf;
    special_res  = '0;
    if (div_zero) begin
      special_res = alu_control[1] ? input_1 : '1;
    end else if (div_ovf) begin
      special_res = alu_control[1] ? '0 : input_1;
    end
  end

  // ---------------- iteration datapath ----------------
  logic [2*WIDTH-1:0] acc_nxt, prod_fix;
  logic [WIDTH-1:0]   quo_nxt, rem_nxt, quo_fix, rem_fix, final_res;
  logic               quo_bit;

  alu_muldiv_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_in       (rem),
    .dividend_bit (a_mag[cnt]),
    .divisor      (b_mag),
    .rem_out      (rem_nxt),
    .quo_bit      (quo_bit)
  );

  // Multiply is Horner-style, MSB of the multiplier first, so the same down-counter
  // indexes both the multiplier bit and the dividend bit.
  always_comb begin
    acc_nxt  = {acc[2*WIDTH-2:0], 1'b0} + (b_mag[cnt] ? {{WIDTH{1'b0}}, a_mag} : '0);
    quo_nxt  = {quo[WIDTH-2:0], quo_bit};
    prod_fix = neg_res ? -acc_nxt : acc_nxt;
    quo_fix  = neg_res ? -quo_nxt : quo_nxt;
    rem_fix  = neg_rem ? -rem_nxt : rem_nxt;
    case (op_q)
      OP_MUL:                       final_res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              final_res = quo_fix;
      OP_REM, OP_REMU:              final_res = rem_fix;
      default:                      final_res = '0;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ready        = 1'b0;
    result_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_nxt = special_case ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt == '0) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        result_valid = 1'b1;
        state_nxt    = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      op_q       <= '0;
      a_mag      <= '0;
      b_mag      <= '0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      acc        <= '0;
      quo        <= '0;
      rem        <= '0;
      alu_result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q    <= alu_control;
            a_mag   <= a_neg ? -input_1 : input_1;
            b_mag   <= b_neg ? -input_2 : input_2;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            acc     <= '0;
            quo     <= '0;
            rem     <= '0;
            cnt     <= CNT_W'(WIDTH - 1);
            if (special_case) begin
              alu_result <= special_res;
            end
          end
        end
        ST_CALC: begin
          acc <= acc_nxt;
          quo <= quo_nxt;
          rem <= rem_nxt;
          if (cnt == '0) begin
            alu_result <= final_res;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
